// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- memory-mapped 8N1 UART receiver with a receive FIFO.
//
// Received bytes from RxD are queued in a small FIFO. The CPU reads them
// through two word registers on the shared SoC bus:
//   BASE_ADDR     DATA   (read pops one byte, writes ignored)
//   BASE_ADDR + 1 STATUS {16'b0, count[7:0], 4'b0, overrun, frame_err, full, empty}
//                        writes: bit3 = 1 clears overrun, bit2 = 1 clears frame_err
//
// Ports
//   clk        system clock, the only clock domain
//   clr        synchronous active-low reset
//   BUS_addr   word address from the bus master
//   BUS_data   bidirectional data, driven here only during a selected read
//   BUS_req    master request, held for the whole transaction
//   BUS_ready  driven 1 while this slave is selected, otherwise 'z
//   BUS_RW     1 = write, 0 = read
//   RxD        asynchronous serial input, idles high
//   RxD_ready  registered, 1 while the FIFO holds at least one byte
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int          CLK_FREQ   = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h3FFF_FFF8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BUS_addr,
    inout  wire  [31:0] BUS_data,
    input  logic        BUS_req,
    inout  wire         BUS_ready,
    input  logic        BUS_RW,
    input  logic        RxD,
    output logic        RxD_ready
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int CPB = CLK_FREQ / BAUD;          // clocks per bit
    localparam int CW  = $clog2(CPB);              // bit-timer width
    localparam int AW  = $clog2(FIFO_DEPTH);       // FIFO pointer width

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2 - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd1;

    // -----------------------------------------------------------------------
    // Input synchroniser. Both flops preset to 1 (line idle) so a reset never
    // looks like a start bit.
    // -----------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    assign rx_s = sync_q[1];

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_push;      // complete frame with a good stop bit
    logic          rx_ferr;      // complete frame with a low stop bit

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        rx_push = 1'b0;
        rx_ferr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit later; a high level there means
            // the falling edge was a glitch.
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // LSB arrives first, so shift in from the top; after eight
            // samples bit 0 has reached shift_q[0].
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Returning to IDLE on a low stop bit lets the still-low line
            // start a new frame attempt immediately.
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        rx_push = 1'b1;
                    end else begin
                        rx_ferr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic sel;
    logic is_data;
    logic rd_data;
    logic wr_stat;
    logic served_q, served_d;

    assign is_data = (BUS_addr == BASE_ADDR);
    assign sel     = BUS_req & (is_data | (BUS_addr == STAT_ADDR));
    assign rd_data = sel & ~BUS_RW & is_data;
    assign wr_stat = sel & BUS_RW & ~is_data;

    // Remembers that this request already had its first cycle, so a master
    // holding BUS_req for several clocks pops only one byte.
    assign served_d = BUS_req & (served_q | sel);

    // -----------------------------------------------------------------------
    // Receive FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          ovr_set;
    logic [7:0]    head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    assign pop = rd_data & ~served_q & ~empty;

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push_ok = rx_push & (~full | pop);
    assign ovr_set = rx_push & full & ~pop;

    // The head must be on the bus in the first selected cycle, so the
    // storage is read combinationally rather than through a read register.
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sticky error flags; a set on the same edge beats a W1C clear.
    // -----------------------------------------------------------------------
    logic ovr_q, ovr_d;
    logic ferr_q, ferr_d;
    logic ready_q;

    always_comb begin
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (wr_stat && BUS_data[3]) begin
            ovr_d = 1'b0;
        end
        if (wr_stat && BUS_data[2]) begin
            ferr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (rx_ferr) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            served_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            served_q <= served_d;
            ready_q  <= ~empty;
        end
    end

    assign RxD_ready = ready_q;

    // -----------------------------------------------------------------------
    // Read mux and bus drivers
    // -----------------------------------------------------------------------
    logic [8:0]  count_ext;
    logic [31:0] status_word;
    logic [31:0] rd_word;

    // Widen first so the count field is well defined for every depth;
    // a 256-entry FIFO reports a full count as 8'h00 (full flag is set).
    assign count_ext   = 9'(count_q);
    assign status_word = {16'b0, count_ext[7:0], 4'b0, ovr_q, ferr_q, full, empty};
    assign rd_word     = is_data ? {24'b0, (empty ? 8'h00 : head)} : status_word;

    assign BUS_data  = (sel && !BUS_RW) ? rd_word : 32'hzzzz_zzzz;
    assign BUS_ready = sel ? 1'b1 : 1'bz;

    // Write data bits that carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{BUS_data[31:4], BUS_data[1:0], count_ext[8]};

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx (CPB = 10, BASE_ADDR = 0x100,
// FIFO_DEPTH = 16). The stimulus process bit-bangs frames and performs bus
// transactions; a single compare process owns a queue-based model and checks
// the bus and RxD_ready every cycle they carry meaning.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam logic [31:0] DATA_A = 32'h100;
    localparam logic [31:0] STAT_A = 32'h101;
    localparam int          CPB    = 10;
    localparam int          DEPTH  = 16;

    logic        clk    = 1'b0;
    logic        clr    = 1'b0;
    logic        req    = 1'b0;
    logic        rw     = 1'b0;
    logic        rxd    = 1'b1;
    logic        wdrive = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    wire  [31:0] bus_data;
    wire         bus_ready;
    logic        rxd_ready;

    assign bus_data = wdrive ? wdata : 32'hzzzz_zzzz;

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .BASE_ADDR (32'h100),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .BUS_addr (addr),
        .BUS_data (bus_data),
        .BUS_req  (req),
        .BUS_ready(bus_ready),
        .BUS_RW   (rw),
        .RxD      (rxd),
        .RxD_ready(rxd_ready)
    );

    always #5 clk = ~clk;

    // Written only by the stimulus process
    logic        ready_chk_en = 1'b0;
    int          ev_cnt       = 0;
    logic [7:0]  ev_byte      = 8'h0;
    logic        ev_good      = 1'b0;
    logic        pin_en       = 1'b0;
    logic [31:0] pin_val      = 32'h0;

    // Written only by the compare process
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mq[$];
    logic        m_ovr    = 1'b0;
    logic        m_ferr   = 1'b0;
    logic        req_prev = 1'b0;
    int          h1       = 0;
    int          h2       = 0;
    int          ev_seen  = 0;

    // -----------------------------------------------------------------------
    // Model + compare
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        logic        hist_set;
        logic [31:0] exp_w;
        hist_set = 1'b0;

        // RxD_ready lags a model change by two sampling points: one edge
        // for the FIFO update and one for the registered flag.
        if (ready_chk_en) begin
            checks++;
            if (rxd_ready !== (h2 != 0)) begin
                failures++;
                $display("FAIL rxd_ready: got %b expected %b at %0t", rxd_ready, (h2 != 0), $time);
            end
        end

        if (!clr) begin
            mq.delete();
            m_ovr    = 1'b0;
            m_ferr   = 1'b0;
            req_prev = 1'b0;
            h1       = 0;
            h2       = 0;
            hist_set = 1'b1;
        end else begin
            if (ev_cnt != ev_seen) begin
                ev_seen = ev_cnt;
                if (ev_good) begin
                    if (mq.size() < DEPTH) mq.push_back(ev_byte);
                    else m_ovr = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
                h1       = mq.size();
                h2       = h1;
                hist_set = 1'b1;
            end

            if (req) begin
                checks++;
                if (bus_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bus_ready: got %b expected 1 at %0t", bus_ready, $time);
                end
                if (!req_prev) begin
                    if (!rw) begin
                        if (addr == DATA_A) begin
                            exp_w = (mq.size() != 0) ? {24'h0, mq[0]} : 32'h0;
                            if (mq.size() != 0) void'(mq.pop_front());
                        end else begin
                            exp_w = {16'h0, 8'(mq.size()), 4'h0, m_ovr, m_ferr,
                                     (mq.size() == DEPTH), (mq.size() == 0)};
                        end
                        checks++;
                        if (bus_data !== exp_w) begin
                            failures++;
                            $display("FAIL read_model addr=%h: got %h expected %h", addr, bus_data, exp_w);
                        end
                        if (pin_en) begin
                            checks++;
                            if (bus_data !== pin_val) begin
                                failures++;
                                $display("FAIL read_literal addr=%h: got %h expected %h", addr, bus_data, pin_val);
                            end
                        end
                    end else if (addr == STAT_A) begin
                        if (wdata[3]) m_ovr = 1'b0;
                        if (wdata[2]) m_ferr = 1'b0;
                    end
                end
            end
            req_prev = req;
        end

        if (!hist_set) begin
            h2 = h1;
            h1 = mq.size();
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int n);
        addr   = a;
        rw     = w;
        wdata  = d;
        wdrive = w;
        req    = 1'b1;
        tick(n);
        req    = 1'b0;
        wdrive = 1'b0;
        pin_en = 1'b0;
        tick(1);
        $display("bus %s addr=%h wdata=%h cycles=%0d", w ? "WR" : "RD", a, d, n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] p);
        pin_val = p;
        pin_en  = 1'b1;
        bus_txn(1'b0, a, 32'h0, 1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ready_chk_en = 1'b0;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
        tick(12);
        ev_byte = b;
        ev_good = stop;
        ev_cnt++;
        tick(2);
        ready_chk_en = 1'b1;
        $display("frame byte=%h stop=%b", b, stop);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        tick(3);
        clr = 1'b1;
        tick(2);
        ready_chk_en = 1'b1;

        // Reset state
        rd(STAT_A, 32'h0000_0001);

        // Single good frame
        send_frame(8'hA5, 1'b1);
        rd(DATA_A, 32'h0000_00A5);
        rd(STAT_A, 32'h0000_0001);
        rd(DATA_A, 32'h0000_0000);

        // Short low glitch must not start a frame
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        rd(STAT_A, 32'h0000_0001);

        // Framing error and its W1C clear
        send_frame(8'h3C, 1'b0);
        rd(STAT_A, 32'h0000_0005);
        bus_txn(1'b1, STAT_A, 32'h0000_0004, 1);
        rd(STAT_A, 32'h0000_0001);

        // Overflow: 17 frames into 16 entries
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        rd(STAT_A, 32'h0000_100A);
        for (int i = 0; i < 16; i++) rd(DATA_A, 32'(i));
        rd(STAT_A, 32'h0000_0009);
        bus_txn(1'b1, STAT_A, 32'h0000_0008, 1);
        rd(STAT_A, 32'h0000_0001);

        // Ignored DATA write, then a long-held read pops once
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        bus_txn(1'b1, DATA_A, 32'h0000_00FF, 1);
        pin_val = 32'h0000_005A;
        pin_en  = 1'b1;
        bus_txn(1'b0, DATA_A, 32'h0, 5);
        rd(STAT_A, 32'h0000_0100);
        rd(DATA_A, 32'h0000_00C3);

        // Reset in the middle of a data bit with bytes queued
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        rd(STAT_A, 32'h0000_0300);
        ready_chk_en = 1'b0;
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(CPB);
        rxd = 1'b0;
        tick(5);
        clr = 1'b0;
        rxd = 1'b1;
        tick(1);
        clr = 1'b1;
        $display("reset pulse mid-frame");
        tick(30);
        ready_chk_en = 1'b1;
        tick(3);
        rd(STAT_A, 32'h0000_0001);
        send_frame(8'h7E, 1'b1);
        rd(DATA_A, 32'h0000_007E);
        rd(STAT_A, 32'h0000_0001);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
